// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid) and registered in_ready.
// Optional MEM-backpressure counter on stall_cnt, enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 4,
  parameter int DST_W  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_store,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_dst,
  output logic [XLEN-1:0]   out_alu,
  output logic [XLEN-1:0]   out_store,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt
);

  // Handshake: a transfer happens on a cycle where valid && ready at the rising edge;
  // flush suppresses both transfers that cycle. in_ready depends only on flops.

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DST_W-1:0]  main_dst_q, skid_dst_q;
  logic [XLEN-1:0]   main_alu_q, skid_alu_q;
  logic [XLEN-1:0]   main_store_q, skid_store_q;

  logic in_xfer, out_xfer;
  logic load_main_in, load_main_skid, load_skid;

  assign in_xfer  = in_valid && in_ready_q && !flush;
  assign out_xfer = main_v_q && out_ready && !flush;

  always_comb begin
    main_v_d       = main_v_q;
    skid_v_d       = skid_v_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (in_xfer) begin
        main_v_d     = 1'b1;
        load_main_in = 1'b1;
      end
    end else if (out_xfer) begin
      // in_ready is low whenever the skid holds data, so no input can arrive here.
      if (skid_v_q) begin
        load_main_skid = 1'b1;
        skid_v_d       = 1'b0;
      end else if (in_xfer) begin
        load_main_in = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      load_skid = 1'b1;
      skid_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= !skid_v_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_ctrl_q  <= '0;
      main_dst_q   <= '0;
      main_alu_q   <= '0;
      main_store_q <= '0;
    end else if (load_main_in) begin
      main_ctrl_q  <= in_ctrl;
      main_dst_q   <= in_dst;
      main_alu_q   <= in_alu;
      main_store_q <= in_store;
    end else if (load_main_skid) begin
      main_ctrl_q  <= skid_ctrl_q;
      main_dst_q   <= skid_dst_q;
      main_alu_q   <= skid_alu_q;
      main_store_q <= skid_store_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_ctrl_q  <= '0;
      skid_dst_q   <= '0;
      skid_alu_q   <= '0;
      skid_store_q <= '0;
    end else if (load_skid) begin
      skid_ctrl_q  <= in_ctrl;
      skid_dst_q   <= in_dst;
      skid_alu_q   <= in_alu;
      skid_store_q <= in_store;
    end
  end

  // Control is gated so a bubble can never assert memwrite/regwrite downstream.
  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_dst   = main_dst_q;
  assign out_alu   = main_alu_q;
  assign out_store = main_store_q;
  assign occupancy = {main_v_q & skid_v_q, main_v_q ^ skid_v_q};

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
    end else if (main_v_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter XLEN, default 64: width of the ALU result and store-data fields.
REQ-002 Parameter CTRL_W, default 4: control bits, [0]=memread, [1]=memwrite, [2]=memtoreg, [3]=regwrite.
REQ-003 Parameter DST_W, default 5: destination register index width.
REQ-004 Port list, one port per line (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  rstn  in  1  reset, asynchronous, active-low
  flush  in  1  synchronous kill of all held entries
  in_valid  in  1  EX presents an instruction
  in_ready  out  1  stage can accept; registered
  in_ctrl  in  CTRL_W  EX control bits
  in_dst  in  DST_W  EX destination index
  in_alu  in  XLEN  EX ALU result
  in_store  in  XLEN  EX forwarded store data
  out_valid  out  1  MEM entry valid
  out_ready  in  1  MEM consumes the entry
  out_ctrl  out  CTRL_W  MEM control bits
  out_dst  out  DST_W  MEM destination index
  out_alu  out  XLEN  MEM ALU result
  out_store  out  XLEN  MEM store data
  occupancy  out  2  entries held (0..2)
  stall_cnt  out  32  MEM-backpressure cycle count

Function
REQ-005 The stage SHALL hold 2 entries: a main entry driving the out_* ports, and a skid entry.
REQ-006 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-007 The latency from an accepted input to out_valid SHALL be exactly 1 cycle when the main entry is empty or transfers out in the same cycle.
REQ-008 in_ready SHALL be a flop and SHALL equal !(skid entry full) for the next cycle; combinational paths from out_ready to in_ready are not allowed.
REQ-009 If an input transfers while the main entry is held and out_ready=0, the input SHALL go to the skid entry.
REQ-010 On an output transfer with the skid entry full, the skid entry SHALL move to the main entry in the next cycle.
REQ-011 A simultaneous input and output transfer with the skid entry empty SHALL replace the main entry; occupancy stays 1.
REQ-012 Order SHALL be FIFO: entries leave in the order they were accepted, with no loss and no duplication.
REQ-013 out_ctrl SHALL read all-zero whenever out_valid=0, so bubbles never assert memwrite or regwrite.
REQ-014 out_dst, out_alu and out_store are don't-care while out_valid=0.
REQ-015 flush=1 SHALL clear both valid bits at the next edge, and clear in_ready=1, out_valid=0 and occupancy=0.
REQ-016 flush SHALL take priority: an in_valid input in the same cycle is dropped and an out_ready in the same cycle is ignored.
REQ-017 flush SHALL NOT clear the data fields; only the valid state and control gating are affected.
REQ-018 occupancy SHALL equal the registered count of valid entries.
REQ-019 Inputs offered while in_ready=0 SHALL be ignored; EX holds them.

Reset
REQ-020 While rstn=0 the stage SHALL drive out_valid=0, out_ctrl=0, out_dst=0, out_alu=0, out_store=0, occupancy=0, in_ready=0 and stall_cnt=0.
REQ-021 At the first clk edge after rstn deasserts, in_ready SHALL rise to 1.
REQ-022 Reset asserted mid-transfer SHALL discard both entries immediately, with no partial outputs.
REQ-023 Every flop SHALL use a nonblocking assignment in the reset branch.

Configuration
REQ-024 With EX_MEM_PERF_EN defined, stall_cnt SHALL increment on each cycle with out_valid && !out_ready, saturate at 32'hFFFFFFFF, and be cleared only by reset.
REQ-025 Without EX_MEM_PERF_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-026 Reset release, then in_valid=1 with ctrl=4'b1001, dst=5, alu=0x10, out_ready=1 -> next cycle out_valid=1, out_ctrl=4'b1001, out_alu=0x10, occupancy=1.
REQ-027 Hold out_ready=0 and send A then B -> occupancy=2, in_ready=0 in the next cycle; raise out_ready -> A then B on consecutive cycles, and in_ready returns to 1.
REQ-028 Continuous stream of 8 entries with out_ready=1 -> one output per cycle, in order, with in_ready constantly 1.
REQ-029 occupancy=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the input is not seen later.
REQ-030 With EX_MEM_PERF_EN, hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; assert rstn=0 mid-stall -> all outputs 0 immediately.
